uart_rx_oversample: RTL

//   Stand-alone UART receiver: oversamples serial line rx, recovers 8N1 frames
//   (8E1 with parity option), buffers bytes in a show-ahead FIFO.

---
 rtl/uart_rx_oversample.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/uart_rx_oversample.sv
// Oversampling UART receiver (8N1) with a show-ahead byte FIFO.
// Define UART_RX_PARITY_EN to receive 8E1 frames with parity checking.
module uart_rx_oversample #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 19200,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx,
    input  logic                          rd_ready,
    output logic [7:0]                    rd_data,
    output logic                          rd_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          rx_done,
    output logic                          frame_err,
    output logic                          overrun_err,
    output logic                          parity_err
);
    localparam int DIV   = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TW    = $clog2(OVERSAMPLE);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam logic [DIV_W-1:0] DIV_M1  = DIV_W'(DIV - 1);
    localparam logic [TW-1:0]    HALF_M1 = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0]    FULL_M1 = TW'(OVERSAMPLE - 1);
    localparam logic [AW:0]      DEPTH_C = (AW + 1)'(FIFO_DEPTH);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
    state_t state_q, state_d;

    logic [1:0]       sync_q;
    logic             rx_s;
    logic [DIV_W-1:0] div_cnt;
    logic [TW-1:0]    tick_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shreg;
    logic             tick, sample, armed;
    logic             res_pend, res_ferr, good, push, pop, full;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
`ifdef UART_RX_PARITY_EN
    logic             par_bit, res_perr;
`endif

    assign rx_s = sync_q[1];

    always_comb begin
        tick    = (state_q != IDLE) && (div_cnt == DIV_M1);
        sample  = tick && (tick_cnt == ((state_q == START) ? HALF_M1 : FULL_M1));
        state_d = state_q;
        case (state_q)
            IDLE:   if (!rx_s && armed) state_d = START;
            START:  if (sample) state_d = rx_s ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
            DATA:   if (sample && bit_cnt == 3'd7) state_d = PARITY;
            PARITY: if (sample) state_d = STOP;
`else
            DATA:   if (sample && bit_cnt == 3'd7) state_d = STOP;
`endif
            STOP:   if (sample) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Frame outcome is resolved one cycle after the stop sample; frame error wins.
    always_comb begin
        full       = (count == DEPTH_C);
        rd_valid   = (count != '0);
        pop        = rd_valid && rd_ready;
        frame_err  = res_pend && res_ferr;
        good       = res_pend && !res_ferr;
`ifdef UART_RX_PARITY_EN
        parity_err = good && res_perr;
        good       = good && !res_perr;
`else
        parity_err = 1'b0;
`endif
        push        = good && (!full || pop);
        overrun_err = good && full && !pop;
        rx_done     = push;
        rd_data     = rd_valid ? mem[rd_ptr] : 8'h00;
        fifo_count  = count;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= 2'b11;
            div_cnt  <= '0;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            armed    <= 1'b1;
            res_pend <= 1'b0;
            res_ferr <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
`ifdef UART_RX_PARITY_EN
            par_bit  <= 1'b0;
            res_perr <= 1'b0;
`endif
        end else begin
            sync_q   <= {sync_q[0], rx};
            res_pend <= 1'b0;
            if (state_q == IDLE) begin
                div_cnt  <= '0;
                tick_cnt <= '0;
                bit_cnt  <= '0;
            end else begin
                div_cnt <= (div_cnt == DIV_M1) ? '0 : div_cnt + 1'b1;
                if (tick) tick_cnt <= sample ? '0 : tick_cnt + 1'b1;
            end
            if (sample && state_q == DATA) begin
                shreg   <= {rx_s, shreg[7:1]};
                bit_cnt <= bit_cnt + 1'b1;
            end
`ifdef UART_RX_PARITY_EN
            if (sample && state_q == PARITY) par_bit <= rx_s;
`endif
            if (sample && state_q == STOP) begin
                res_pend <= 1'b1;
                res_ferr <= !rx_s;
`ifdef UART_RX_PARITY_EN
                res_perr <= (par_bit != ^shreg);
`endif
            end
            // A low stop bit may be a break: wait for the line to go high again.
            if (sample && state_q == STOP && !rx_s) armed <= 1'b0;
            else if (rx_s)                          armed <= 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= shreg;
    end
endmodule
